// File: rtl/td4x_pkg.sv
// td4x_pkg: opcodes and FSM encoding shared by the TD4X core files.
// The optional CALL/RET return stack is built only with TD4X_CALL_EN.
package td4x_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_CALL   = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_RET    = 4'b1010;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_NOP    = 4'b1100;
    localparam logic [3:0] OP_HALT   = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/td4x_if.sv
// td4x_if: instruction-fetch req/valid bus between core and program memory.
// The core is the master (drives address/request), memory the slave.
interface td4x_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_req;
    logic                imem_vld;
    logic [DATA_W+3:0]   imem_data;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_vld,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_vld,
        output imem_data
    );
endinterface

// File: rtl/td4x_ret_stack.sv
// td4x_ret_stack: LIFO of return addresses for CALL/RET.
// Compiled only when TD4X_CALL_EN is defined; otherwise the core has no stack.
`ifdef TD4X_CALL_EN
module td4x_ret_stack #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[IDX_W'(sp - SP_W'(1))];

    // Stack pointer: counts live entries, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage: written at the current pointer on push, never reset
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IDX_W'(sp)] <= din;
        end
    end
endmodule
`endif

// File: rtl/td4x_core.sv
// td4x_core: TD4-compatible CPU with req/valid instruction fetch and HALT.
// Define TD4X_CALL_EN to add CALL/RET with a STACK_DEPTH return stack.
module td4x_core
    import td4x_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    td4x_if.master            bus,
    input  logic [DATA_W-1:0] port_i,
    output logic [DATA_W-1:0] port_o,
    output logic              port_o_we,
    output logic              cf,
    output logic              halted,
    output logic              stk_err
);
    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] call_pc;
    logic [ADDR_W-1:0] ret_pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ir_op;
    logic [DATA_W-1:0] ir_imm;
    logic [DATA_W-1:0] src;
    logic [DATA_W:0]   sum;
    logic              alu_op;
    logic              accept;
    logic              exec;
    logic              stk_fault;

    assign accept = (state == ST_FETCH) && bus.imem_vld;
    assign exec   = (state == ST_EXEC);
    assign pc_inc = pc + ADDR_W'(1);
    assign tgt    = ADDR_W'(ir_imm);
    assign sum    = {1'b0, src} + {1'b0, ir_imm};

`ifdef TD4X_CALL_EN
    logic stk_full;
    logic stk_empty;
    logic stk_push;
    logic stk_pop;

    assign stk_push  = exec && (ir_op == OP_CALL) && !stk_full;
    assign stk_pop   = exec && (ir_op == OP_RET) && !stk_empty;
    assign stk_fault = exec && (((ir_op == OP_CALL) && stk_full)
                             || ((ir_op == OP_RET) && stk_empty));
    assign call_pc   = tgt;

    td4x_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (ret_pc),
        .full  (stk_full),
        .empty (stk_empty)
    );
`else
    logic unused_cfg;

    assign stk_fault  = 1'b0;
    assign call_pc    = pc_inc;
    assign ret_pc     = pc_inc;
    assign unused_cfg = (STACK_DEPTH > 0);
`endif

    // ALU source select; MOV imm adds to zero so its carry is always clear
    always_comb begin
        src    = '0;
        alu_op = 1'b1;
        unique case (ir_op)
            OP_ADD_A, OP_MOV_BA: src = a;
            OP_ADD_B, OP_MOV_AB: src = b;
            OP_IN_A, OP_IN_B:    src = port_i;
            OP_MOV_A, OP_MOV_B:  src = '0;
            default:             alu_op = 1'b0;
        endcase
    end

    // Next PC; a halt or stack fault parks the PC on the faulting op
    always_comb begin
        pc_nx = pc_inc;
        unique case (ir_op)
            OP_JMP:  pc_nx = tgt;
            OP_JNC:  if (!cf) pc_nx = tgt;
            OP_HALT: pc_nx = pc;
            OP_CALL: pc_nx = stk_fault ? pc : call_pc;
            OP_RET:  pc_nx = stk_fault ? pc : ret_pc;
            default: pc_nx = pc_inc;
        endcase
    end

    // Architectural state: IR on fetch accept, regs/flags/PC in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            a       <= '0;
            b       <= '0;
            port_o  <= '0;
            cf      <= 1'b0;
            stk_err <= 1'b0;
            ir_op   <= OP_NOP;
            ir_imm  <= '0;
        end else begin
            if (accept) begin
                {ir_op, ir_imm} <= bus.imem_data;
            end
            if (exec) begin
                pc <= pc_nx;
                if (alu_op) cf <= sum[DATA_W];
                unique case (ir_op)
                    OP_ADD_A, OP_MOV_A, OP_MOV_AB, OP_IN_A:
                        a <= sum[DATA_W-1:0];
                    OP_ADD_B, OP_MOV_B, OP_MOV_BA, OP_IN_B:
                        b <= sum[DATA_W-1:0];
                    OP_OUT_B: port_o <= b;
                    OP_OUT_I: port_o <= ir_imm;
                    default:  ;
                endcase
                if (stk_fault) stk_err <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nx;
    end

    // FSM next state: wait for valid, execute once, HALT is terminal
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FETCH: if (bus.imem_vld) state_nx = ST_EXEC;
            ST_EXEC:  state_nx = ((ir_op == OP_HALT) || stk_fault)
                               ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nx = ST_HALT;
            default:  state_nx = ST_FETCH;
        endcase
    end

    // FSM outputs: request only in FETCH, output strobe in EXEC of an OUT
    always_comb begin
        bus.imem_addr = pc;
        bus.imem_req  = (state == ST_FETCH);
        halted        = (state == ST_HALT);
        port_o_we     = exec && ((ir_op == OP_OUT_B) || (ir_op == OP_OUT_I));
    end
endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: randomized-memory-latency scoreboard bench for td4x_core.
// Honours TD4X_CALL_EN in its ISA reference model.
module tb_td4x_core;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int SD = 2;

    typedef struct {
        int pc;
        int cf;
        int po;
        int we;
        int hlt;
        int err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] port_i = '0;
    logic [DW-1:0] port_o;
    logic          port_o_we;
    logic          cf;
    logic          halted;
    logic          stk_err;

    td4x_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    td4x_core #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .port_i    (port_i),
        .port_o    (port_o),
        .port_o_we (port_o_we),
        .cf        (cf),
        .halted    (halted),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic [7:0] prog [16];
    int   n_exec;

    int   m_pc, m_a, m_b, m_out, m_cf, m_halt, m_err;
    int   m_stk[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_out = 0;
        m_cf = 0; m_halt = 0; m_err = 0;
        m_stk.delete();
    endtask

    // ISA-level reference: one instruction, then queue the visible result
    task automatic model_step(input logic [7:0] ins, input int pin);
        int op, imm, nxt, res;
        bit to_a, to_b;
        exp_t e;
        op = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        nxt = (m_pc + 1) % (1 << AW);
        res = 0; to_a = 0; to_b = 0; e.we = 0;
        case (op)
            0:  begin res = m_a + imm; to_a = 1; end
            1:  begin res = m_b + imm; to_a = 1; end
            2:  begin res = pin + imm; to_a = 1; end
            3:  begin res = imm;       to_a = 1; end
            4:  begin res = m_a + imm; to_b = 1; end
            5:  begin res = m_b + imm; to_b = 1; end
            6:  begin res = pin + imm; to_b = 1; end
            7:  begin res = imm;       to_b = 1; end
            9:  begin m_out = m_b; e.we = 1; end
            11: begin m_out = imm; e.we = 1; end
            15: nxt = imm % (1 << AW);
            14: if (m_cf == 0) nxt = imm % (1 << AW);
            13: m_halt = 1;
`ifdef TD4X_CALL_EN
            8: begin
                if (m_stk.size() == SD) begin m_err = 1; m_halt = 1; end
                else begin m_stk.push_back(nxt); nxt = imm % (1 << AW); end
            end
            10: begin
                if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; end
                else nxt = m_stk.pop_back();
            end
`endif
            default: ;
        endcase
        if (to_a || to_b) begin
            m_cf = (res >= (1 << DW)) ? 1 : 0;
            res = res % (1 << DW);
            if (to_a) m_a = res;
            else m_b = res;
        end
        if (m_halt == 0) m_pc = nxt;
        e.pc = m_pc; e.cf = m_cf; e.po = m_out;
        e.hlt = m_halt; e.err = m_err;
        q.push_back(e);
    endtask

    // Memory with random wait states; garbage on the bus when not accepted
    task automatic drive_cycle();
        if (bus.imem_req && !rst && (m_halt == 0)) begin
            port_i = DW'($urandom);
            if ($urandom_range(0, 99) < 60) begin
                bus.imem_vld  = 1'b1;
                bus.imem_data = prog[bus.imem_addr];
                model_step(prog[m_pc], int'(port_i));
                n_exec++;
            end else begin
                bus.imem_vld  = 1'b0;
                bus.imem_data = 8'($urandom);
            end
        end else begin
            bus.imem_vld  = 1'($urandom);
            bus.imem_data = 8'($urandom);
        end
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 16; i++) prog[i] = 8'hC0;
        case (p)
            0: begin
                prog[0] = 8'h33; prog[1] = 8'h05; prog[2] = 8'h40;
                prog[3] = 8'h90; prog[4] = 8'h09; prog[5] = 8'h40;
                prog[6] = 8'h90; prog[7] = 8'hD0;
            end
            1: begin
                prog[0] = 8'h31; prog[1] = 8'h0F; prog[2] = 8'hE0;
                prog[3] = 8'h30; prog[4] = 8'hE6; prog[5] = 8'hD0;
                prog[6] = 8'hBA; prog[7] = 8'hD0;
            end
            2: prog[0] = 8'hBA;
            3: begin
                prog[0] = 8'h84; prog[1] = 8'hB1; prog[2] = 8'h88;
                prog[3] = 8'hD0; prog[4] = 8'h86; prog[5] = 8'hA0;
                prog[6] = 8'hB6; prog[7] = 8'hA0; prog[8] = 8'h89;
                prog[9] = 8'h8A; prog[10] = 8'h8B;
            end
            default: for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        bus.imem_vld  = 1'($urandom);
        bus.imem_data = 8'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_req", int'(bus.imem_req), 1);
        chk("rst_addr", int'(bus.imem_addr), 0);
        chk("rst_port_o", int'(port_o), 0);
        chk("rst_we", int'(port_o_we), 0);
        chk("rst_cf", int'(cf), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_stk_err", int'(stk_err), 0);
        drive_cycle();
    endtask

    // Monitor: accept -> EXEC (capture strobe) -> compare architectural view
    initial begin
        int stage;
        bit wait_prev;
        int we_s;
        int last_addr;
        exp_t e;
        stage = 0; wait_prev = 0; we_s = 0; last_addr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stage = 0;
                wait_prev = 0;
                continue;
            end
            if (stage == 1) begin
                we_s = int'(port_o_we);
                chk("exec_req", int'(bus.imem_req), 0);
                stage = 2;
            end else if (stage == 2) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got no expectation, required one");
                end else begin
                    e = q.pop_front();
                    if (e.hlt == 0) chk("pc", int'(bus.imem_addr), e.pc);
                    chk("cf", int'(cf), e.cf);
                    chk("port_o", int'(port_o), e.po);
                    chk("out_we", we_s, e.we);
                    chk("halted", int'(halted), e.hlt);
                    chk("stk_err", int'(stk_err), e.err);
                end
                stage = 0;
            end
            if (stage == 0 && bus.imem_req && wait_prev)
                chk("addr_hold", int'(bus.imem_addr), last_addr);
            wait_prev = bus.imem_req && !bus.imem_vld;
            last_addr = int'(bus.imem_addr);
            if (stage == 0 && bus.imem_req && bus.imem_vld) stage = 1;
        end
    end

    initial begin
        int budget;
        bus.imem_vld  = 1'b0;
        bus.imem_data = '0;
        for (int p = 0; p < 14; p++) begin
            load_prog(p);
            do_reset();
            n_exec = 0;
            budget = 0;
            while ((m_halt == 0) && (n_exec < 40) && (budget < 600)) begin
                @(posedge clk); #1;
                drive_cycle();
                budget++;
            end
            if (budget >= 600) begin
                checks++;
                failures++;
                $display("FAIL run_timeout: prog %0d got %0d instrs, required 40", p, n_exec);
            end
            repeat (4) begin
                @(posedge clk); #1;
                drive_cycle();
            end
            if (m_halt != 0) begin
                chk("halt_hold", int'(halted), 1);
                chk("halt_req", int'(bus.imem_req), 0);
            end
        end
        bus.imem_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
